wrr_arbiter: RTL and testbench

WRR_ARBITER -- requirements
Module: wrr_arbiter

---
 rtl/wrr_arbiter.sv | 116 +++++++++++
 tb/tb_wrr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held for up to
// weight[i] acked transfers, with same-edge regrant on release.
`timescale 1ns/1ps
module wrr_arbiter #(
    parameter int REQ_WIDTH    = 4,
    parameter int WEIGHT_WIDTH = 4,
    localparam int IDW         = $clog2(REQ_WIDTH)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [REQ_WIDTH-1:0]              req,
    input  logic [REQ_WIDTH*WEIGHT_WIDTH-1:0] weight,
    input  logic                              ack,
    output logic [REQ_WIDTH-1:0]              gnt,
    output logic [IDW-1:0]                    gnt_id,
    output logic                              gnt_valid,
    output logic [WEIGHT_WIDTH-1:0]           credit
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [IDW-1:0]          id_q, id_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic [IDW-1:0]          base, sel;
    logic                    rel;

    // First set bit scanning cyclically from base+1; base itself comes last.
    function automatic logic [IDW-1:0] pick(
        input logic [REQ_WIDTH-1:0] r,
        input logic [IDW-1:0]       b
    );
        logic [IDW-1:0] s;
        logic           found;
        int             idx;
        s     = '0;
        found = 1'b0;
        for (int i = 1; i <= REQ_WIDTH; i++) begin
            idx = (int'(b) + i) % REQ_WIDTH;
            if (!found && r[idx]) begin
                s     = IDW'(idx);
                found = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic [WEIGHT_WIDTH-1:0] load(input logic [IDW-1:0] id);
        logic [WEIGHT_WIDTH-1:0] w;
        w = weight[int'(id)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        return (w == '0) ? WEIGHT_WIDTH'(1) : w;
    endfunction

    assign base = (state_q == IDLE) ? ptr_q : id_q;
    assign sel  = pick(req, base);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        credit_d = credit_q;
        rel      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = GRANT;
                    id_d     = sel;
                    credit_d = load(sel);
                end
            end
            GRANT: begin
                if (!req[id_q]) begin
                    rel = 1'b1;
                end else if (ack) begin
                    if (credit_q == WEIGHT_WIDTH'(1))
                        rel = 1'b1;
                    else
                        credit_d = credit_q - WEIGHT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (rel) begin
            ptr_d = id_q;
            if (|req) begin
                id_d     = sel;
                credit_d = load(sel);
            end else begin
                state_d  = IDLE;
                id_d     = '0;
                credit_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= IDW'(REQ_WIDTH - 1);
            id_q     <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            credit_q <= credit_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt       = gnt_valid ? (REQ_WIDTH'(1) << id_q) : '0;
    assign gnt_id    = id_q;
    assign credit    = credit_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: round robin, weights, drops, holds, async reset.
`timescale 1ns/1ps
module tb_wrr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ack;
    logic [3:0]  req;
    logic [15:0] weight;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_valid;
    logic [3:0]  credit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wrr_arbiter #(.REQ_WIDTH(4), .WEIGHT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .req(req), .weight(weight), .ack(ack),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .credit(credit)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time=%0t required finish", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        ack   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        req    = 4'b1111;
        ack    = 1'b1;
        weight = 16'h1111;
        step();
        step();
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", gnt_id); end
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", gnt_valid); end
        total++; if (credit !== 4'd0) begin bad++; $display("FAIL reset_credit got=%0d want=0", credit); end
        reset = 1'b0;
        req   = '0;
        ack   = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        apply_reset();
        weight = 16'h1111;
        req    = 4'b1111;
        ack    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            eg = 4'b0001 << (k % 4);
            total++; if (gnt !== eg) begin bad++; $display("FAIL rr_gnt[%0d] got=%b want=%b", k, gnt, eg); end
            total++; if (gnt_id !== 2'(k % 4)) begin bad++; $display("FAIL rr_id[%0d] got=%0d want=%0d", k, gnt_id, k % 4); end
            total++; if (gnt_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%b want=1", k, gnt_valid); end
            total++; if (credit !== 4'd1) begin bad++; $display("FAIL rr_credit[%0d] got=%0d want=1", k, credit); end
        end
    endtask

    task automatic test_weighted();
        logic [3:0] eg [5];
        logic [3:0] ec [5];
        eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
        ec = '{4'd3, 4'd2, 4'd1, 4'd1, 4'd3};
        apply_reset();
        weight = 16'h1113;
        req    = 4'b0011;
        ack    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            total++; if (gnt !== eg[k]) begin bad++; $display("FAIL wt_gnt[%0d] got=%b want=%b", k, gnt, eg[k]); end
            total++; if (credit !== ec[k]) begin bad++; $display("FAIL wt_credit[%0d] got=%0d want=%0d", k, credit, ec[k]); end
        end
    endtask

    task automatic test_drop();
        apply_reset();
        weight = 16'h2500;
        req    = 4'b0100;
        ack    = 1'b0;
        step();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL drop_gnt got=%b want=0100", gnt); end
        total++; if (credit !== 4'd5) begin bad++; $display("FAIL drop_load got=%0d want=5", credit); end
        ack = 1'b1;
        weight[11:8] = 4'd9;
        step();
        total++; if (credit !== 4'd4) begin bad++; $display("FAIL drop_c4 got=%0d want=4", credit); end
        step();
        total++; if (credit !== 4'd3) begin bad++; $display("FAIL drop_c3 got=%0d want=3", credit); end
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL drop_hold got=%b want=0100", gnt); end
        req = 4'b1001;
        step();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL drop_next got=%b want=1000", gnt); end
        total++; if (gnt_id !== 2'd3) begin bad++; $display("FAIL drop_next_id got=%0d want=3", gnt_id); end
        total++; if (credit !== 4'd2) begin bad++; $display("FAIL drop_next_credit got=%0d want=2", credit); end
        req = 4'b0000;
        step();
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL idle_gnt got=%b want=0000", gnt); end
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", gnt_valid); end
        total++; if (credit !== 4'd0) begin bad++; $display("FAIL idle_credit got=%0d want=0", credit); end
        step();
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL idle_ack got=%b want=0", gnt_valid); end
        req = 4'b1001;
        step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL idle_ptr got=%b want=0001", gnt); end
    endtask

    task automatic test_zero_weight();
        apply_reset();
        weight = 16'h0000;
        req    = 4'b0010;
        ack    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL zw_gnt[%0d] got=%b want=0010", k, gnt); end
            total++; if (credit !== 4'd1) begin bad++; $display("FAIL zw_credit[%0d] got=%0d want=1", k, credit); end
            total++; if (gnt_valid !== 1'b1) begin bad++; $display("FAIL zw_valid[%0d] got=%b want=1", k, gnt_valid); end
        end
    endtask

    task automatic test_hold();
        apply_reset();
        weight = 16'h2111;
        req    = 4'b1000;
        ack    = 1'b0;
        step();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL hold_gnt got=%b want=1000", gnt); end
        req = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            step();
            total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL hold_gnt[%0d] got=%b want=1000", k, gnt); end
            total++; if (credit !== 4'd2) begin bad++; $display("FAIL hold_credit[%0d] got=%0d want=2", k, credit); end
        end
        ack = 1'b1;
        step();
        total++; if (credit !== 4'd1) begin bad++; $display("FAIL hold_dec got=%0d want=1", credit); end
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL hold_dec_gnt got=%b want=1000", gnt); end
        step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL hold_wrap got=%b want=0001", gnt); end
        total++; if (credit !== 4'd1) begin bad++; $display("FAIL hold_wrap_credit got=%0d want=1", credit); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        weight = 16'h0300;
        req    = 4'b0100;
        ack    = 1'b0;
        step();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL ar_pre got=%b want=0100", gnt); end
        #3 reset = 1'b1;
        #1;
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL ar_gnt got=%b want=0000", gnt); end
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", gnt_valid); end
        total++; if (credit !== 4'd0) begin bad++; $display("FAIL ar_credit got=%0d want=0", credit); end
        #1 reset = 1'b0;
        step();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL ar_regrant got=%b want=0100", gnt); end
        total++; if (credit !== 4'd3) begin bad++; $display("FAIL ar_regrant_credit got=%0d want=3", credit); end
    endtask

    initial begin
        reset  = 1'b1;
        req    = '0;
        ack    = 1'b0;
        weight = '0;
        test_reset();
        test_round_robin();
        test_weighted();
        test_drop();
        test_zero_weight();
        test_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
